// File: rtl/layer_sched_if.sv
// Signal bundle around the layer scheduler. It carries the scan position from
// the timing driver, the address broadcast and the replies from the sprite
// sources, the composited pixel, the collision report, and the game-logic
// update handshake.
interface layer_sched_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 12,
  parameter int X_W        = 10,
  parameter int Y_W        = 10
);
  logic [X_W-1:0]              scan_x_i;
  logic [Y_W-1:0]              scan_y_i;
  logic                        scan_disp_i;
  logic [X_W-1:0]              lyr_x_o;
  logic [Y_W-1:0]              lyr_y_o;
  logic [NUM_LAYERS*RGB_W-1:0] lyr_rgb_i;
  logic [NUM_LAYERS-1:0]       lyr_alpha_i;
  logic [RGB_W-1:0]            pix_rgb_o;
  logic                        pix_valid_o;
  logic [NUM_LAYERS-1:0]       coll_o;
  logic                        frame_done_o;
  logic                        upd_req_o;
  logic                        upd_ack_i;
  logic                        overrun_o;

  // Scheduler side.
  modport master (
    input  scan_x_i, scan_y_i, scan_disp_i, lyr_rgb_i, lyr_alpha_i, upd_ack_i,
    output lyr_x_o, lyr_y_o, pix_rgb_o, pix_valid_o, coll_o, frame_done_o,
           upd_req_o, overrun_o
  );

  // Environment side: timing driver, sprite sources, pixel sink and game logic.
  modport slave (
    output scan_x_i, scan_y_i, scan_disp_i, lyr_rgb_i, lyr_alpha_i, upd_ack_i,
    input  lyr_x_o, lyr_y_o, pix_rgb_o, pix_valid_o, coll_o, frame_done_o,
           upd_req_o, overrun_o
  );
endinterface

// File: rtl/layer_sched.sv
// Per-pixel layer scheduler and compositor on the VGA pixel clock.
// The scan address is broadcast to every sprite source. Each source answers
// one cycle later with a colour and an opaque flag. The lowest-index opaque
// layer wins the pixel. Overlaps with the player plane (layer 0) are collected
// into per-frame collision flags. After the last active line has been composed,
// the flags are reported and an update window is offered to the game logic.
// The window lasts until the game logic acknowledges it or the next frame
// starts.
module layer_sched #(
  parameter int               NUM_LAYERS = 4,
  parameter int               RGB_W      = 12,
  parameter int               X_W        = 10,
  parameter int               Y_W        = 10,
  parameter int               V_ACTIVE   = 480,
  parameter logic [RGB_W-1:0] BG_RGB     = '0
) (
  input  logic          clk_vga,
  input  logic          rst,
  layer_sched_if.master bus
);

  typedef enum logic [1:0] {SCAN, DRAIN, REPORT, WINDOW} state_t;

  state_t                state;
  logic                  drain_cnt;
  logic                  vld_p1;
  logic                  vld_p2;
  logic [RGB_W-1:0]      pix_rgb_p2;
  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] coll_q;
  logic                  frame_done_q;
  logic                  upd_req_q;
  logic                  overrun_q;
  logic                  frame_end;
  logic                  disp_rise;

  // Lowest-index opaque layer wins; background shows through when none is opaque.
  function automatic logic [RGB_W-1:0] pick_rgb(
    input logic [NUM_LAYERS*RGB_W-1:0] rgb,
    input logic [NUM_LAYERS-1:0]       alpha
  );
    logic [RGB_W-1:0] sel;
    sel = BG_RGB;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (alpha[k]) sel = rgb[k*RGB_W +: RGB_W];
    end
    return sel;
  endfunction

  // ---- stage p0: scan address goes straight out to the sprite sources ----
  assign bus.lyr_x_o = bus.scan_x_i;
  assign bus.lyr_y_o = bus.scan_y_i;

  // ---- stage p1: layer replies line up with the delayed display flag ----
  // The last active line ends when the display flag falls on it.
  assign frame_end = vld_p1 && !bus.scan_disp_i &&
                     (bus.scan_y_i == Y_W'(V_ACTIVE - 1));
  assign disp_rise = bus.scan_disp_i && !vld_p1;
  // Player plane overlapped by another opaque layer on an active pixel.
  assign hit = (vld_p1 && bus.lyr_alpha_i[0]) ?
               {bus.lyr_alpha_i[NUM_LAYERS-1:1], 1'b0} : '0;

  // Compose pipeline: delay the display flag, then register the winning colour.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      pix_rgb_p2 <= '0;
    end else begin
      vld_p1     <= bus.scan_disp_i;
      vld_p2     <= vld_p1;
      pix_rgb_p2 <= vld_p1 ? pick_rgb(bus.lyr_rgb_i, bus.lyr_alpha_i) : '0;
    end
  end

  // ---- stage p2: composited pixel out ----
  assign bus.pix_rgb_o   = pix_rgb_p2;
  assign bus.pix_valid_o = vld_p2;

  // Frame sequencer: collect collisions, drain, report, then run the update window.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state        <= SCAN;
      drain_cnt    <= 1'b0;
      acc          <= '0;
      coll_q       <= '0;
      frame_done_q <= 1'b0;
      upd_req_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      acc          <= acc | hit;
      case (state)
        SCAN: begin
          if (frame_end) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        // Two cycles so the final pixel is composed and its collisions counted.
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state        <= REPORT;
            frame_done_q <= 1'b1;
          end
        end
        REPORT: begin
          coll_q    <= acc;
          acc       <= '0;
          upd_req_q <= 1'b1;
          state     <= WINDOW;
        end
        // A late acknowledge on the very cycle video restarts still counts as on time.
        WINDOW: begin
          if (bus.upd_ack_i) begin
            upd_req_q <= 1'b0;
            state     <= SCAN;
          end else if (disp_rise) begin
            upd_req_q <= 1'b0;
            overrun_q <= 1'b1;
            state     <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.coll_o       = coll_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.upd_req_o    = upd_req_q;
  assign bus.overrun_o    = overrun_q;

endmodule

// File: tb/tb_layer_sched.sv
// Testbench for layer_sched. It uses a shrunken raster (24x6 active inside
// 32x9 total), random layer colours and alphas, and per-frame scenarios for
// collisions, resets and the update handshake. Expected values come from a
// cycle-indexed reference model of the compositing and frame-report rules.
module tb_layer_sched;
  localparam int NL    = 4;
  localparam int RW    = 12;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int H_ACT = 24;
  localparam int H_TOT = 32;
  localparam int V_ACT = 6;
  localparam int V_TOT = 9;
  localparam int N_FR  = 11;
  localparam int K_RAND = 0, K_ONE = 1, K_NONE = 2, K_LAST = 3, K_DIR = 4;

  logic clk_vga = 1'b0;
  logic rst     = 1'b1;

  layer_sched_if #(.NUM_LAYERS(NL), .RGB_W(RW), .X_W(XW), .Y_W(YW)) bus();

  layer_sched #(
    .NUM_LAYERS(NL), .RGB_W(RW), .X_W(XW), .Y_W(YW),
    .V_ACTIVE(V_ACT), .BG_RGB(12'h000)
  ) dut (
    .clk_vga(clk_vga),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_vga = ~clk_vga;

  // Per-frame scenario: layer pattern and ack delay (-1 never, -2 random 0..60).
  int sc_kind [N_FR] = '{K_RAND, K_ONE, K_NONE, K_LAST, K_DIR, K_RAND,
                         K_RAND, K_ONE, K_RAND, K_RAND, K_RAND};
  int sc_ack  [N_FR] = '{50, 0, -2, -2, -2, -2, -1, -1, 10, 5, -2};

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int hx = 0, vy = 0, fr = 0;
  int px = 0, py = 0, pfr = 0;
  logic pdisp = 1'b0;

  logic [RW-1:0] exp_pix  = '0;
  logic          exp_vld  = 1'b0;
  logic          exp_req  = 1'b0;
  logic          exp_ovr  = 1'b0;
  logic [NL-1:0] exp_coll = '0;
  logic [NL-1:0] m_acc    = '0;
  logic          m_d1     = 1'b0;
  int fd_cyc = -1, rep_fr = 0, win_cnt = 0, win_delay = -1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } cchk_t;
  cchk_t cq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic sched(input int c, input int sel, input logic [31:0] v, input string tag);
    cchk_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.tag = tag;
    cq.push_back(e);
  endtask

  function automatic logic [RW-1:0] ref_pick(input logic [NL*RW-1:0] rgb,
                                             input logic [NL-1:0] a);
    for (int k = 0; k < NL; k++) begin
      if (a[k]) return rgb[k*RW +: RW];
    end
    return 12'h000;
  endfunction

  task automatic tick();
    logic          disp, rst_v, ack, n_req, n_ovr;
    logic [NL*RW-1:0] rgb;
    logic [NL-1:0] alpha, n_coll;
    logic [RW-1:0] n_pix;
    int            kind;

    // Outputs for this cycle, compared against the model.
    chk("pix_rgb",    32'(bus.pix_rgb_o),    32'(exp_pix));
    chk("pix_valid",  32'(bus.pix_valid_o),  32'(exp_vld));
    chk("frame_done", 32'(bus.frame_done_o), 32'(cyc == fd_cyc));
    chk("upd_req",    32'(bus.upd_req_o),    32'(exp_req));
    chk("overrun",    32'(bus.overrun_o),    32'(exp_ovr));
    chk("coll",       32'(bus.coll_o),       32'(exp_coll));
    while (cq.size() > 0 && cq[0].cyc <= cyc) begin
      chk(cq[0].tag, (cq[0].sel != 0) ? 32'(bus.coll_o) : 32'(bus.pix_rgb_o), cq[0].val);
      void'(cq.pop_front());
    end

    // Timing driver and sprite sources (sources answer for last cycle's address).
    disp  = (hx < H_ACT) && (vy < V_ACT);
    rst_v = (fr == 0 && vy == 0 && hx < 3) ||
            (fr == 5 && vy == 2 && hx >= 7 && hx < 10) ||
            (fr == 9 && vy == 1 && hx >= 3 && hx < 6);
    kind  = sc_kind[pfr];
    for (int k = 0; k < NL; k++) rgb[k*RW +: RW] = RW'($urandom);
    alpha = NL'($urandom);
    if (pdisp) begin
      case (kind)
        K_ONE:  alpha = (px == 10 && py == 3) ? 4'b1001 : 4'b0001;
        K_NONE: alpha = 4'b0001;
        K_LAST: alpha = (px == H_ACT-1 && py == V_ACT-1) ? 4'b1001 : 4'b0001;
        K_DIR: begin
          if (px == 2 && py == 0) begin
            alpha = 4'b0110;
            rgb[RW +: RW]   = 12'hF00;
            rgb[2*RW +: RW] = 12'h0F0;
            sched(cyc + 1, 0, 32'hF00, "prio_f00");
          end else if (px == 3 && py == 0) begin
            alpha = 4'b0000;
            sched(cyc + 1, 0, 32'h000, "bg_rgb");
          end
        end
        default: ;
      endcase
    end else if (kind == K_NONE) begin
      alpha = 4'b1111;
    end
    if (rst_v) alpha = 4'b1111;

    // Game logic: ack after the scenario delay inside the window, noise outside.
    if (exp_req) begin
      ack = (win_delay >= 0) && (win_cnt >= win_delay);
      win_cnt++;
    end else begin
      ack = 1'($urandom_range(0, 1));
    end

    rst              = rst_v;
    bus.scan_x_i     = XW'(hx);
    bus.scan_y_i     = YW'(vy);
    bus.scan_disp_i  = disp;
    bus.lyr_rgb_i    = rgb;
    bus.lyr_alpha_i  = alpha;
    bus.upd_ack_i    = ack;
    #1;
    chk("lyr_x", 32'(bus.lyr_x_o), 32'(hx));
    chk("lyr_y", 32'(bus.lyr_y_o), 32'(vy));
    if (rst_v) begin
      chk("rst_pix",  32'({bus.pix_rgb_o, bus.pix_valid_o}), 32'h0);
      chk("rst_coll", 32'(bus.coll_o), 32'h0);
      chk("rst_ctl",  32'({bus.frame_done_o, bus.upd_req_o, bus.overrun_o}), 32'h0);
    end

    // Reference model: what the outputs must show after this cycle's clock edge.
    if (rst_v) begin
      exp_pix = '0; exp_vld = 1'b0; exp_req = 1'b0; exp_ovr = 1'b0;
      exp_coll = '0; m_acc = '0; m_d1 = 1'b0; fd_cyc = -1;
    end else begin
      n_pix  = m_d1 ? ref_pick(rgb, alpha) : '0;
      n_req  = exp_req;
      n_ovr  = exp_ovr;
      n_coll = exp_coll;
      if (cyc == fd_cyc) begin
        n_coll  = m_acc;
        m_acc   = '0;
        n_req   = 1'b1;
        win_cnt = 0;
        win_delay = (sc_ack[rep_fr] == -2) ? int'($urandom_range(0, 60)) : sc_ack[rep_fr];
        case (sc_kind[rep_fr])
          K_ONE, K_LAST: sched(cyc + 1, 1, 32'h8, "coll_hit");
          K_NONE:        sched(cyc + 1, 1, 32'h0, "coll_none");
          default: ;
        endcase
      end else if (m_d1 && alpha[0]) begin
        for (int k = 1; k < NL; k++) if (alpha[k]) m_acc[k] = 1'b1;
      end
      if (exp_req) begin
        if (ack) begin
          n_req = 1'b0;
        end else if (disp && !m_d1) begin
          n_req = 1'b0;
          n_ovr = 1'b1;
        end
      end
      if (m_d1 && !disp && vy == V_ACT-1) begin
        fd_cyc = cyc + 3;
        rep_fr = fr;
      end
      exp_pix  = n_pix;
      exp_vld  = m_d1;
      exp_req  = n_req;
      exp_ovr  = n_ovr;
      exp_coll = n_coll;
      m_d1     = disp;
    end

    @(posedge clk_vga);
    px = hx; py = vy; pdisp = disp; pfr = fr;
    hx++;
    if (hx == H_TOT) begin
      hx = 0;
      vy++;
      if (vy == V_TOT) begin
        vy = 0;
        fr++;
      end
    end
    @(negedge clk_vga);
    cyc++;
  endtask

  initial begin
    bus.scan_x_i    = '0;
    bus.scan_y_i    = '0;
    bus.scan_disp_i = 1'b0;
    bus.lyr_rgb_i   = '0;
    bus.lyr_alpha_i = '0;
    bus.upd_ack_i   = 1'b0;
    rst             = 1'b1;
    @(negedge clk_vga);
    while (fr < N_FR) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
- Per-pixel layer scheduler and compositor for the VGA path, clocked on clk_vga.
- Takes the pixel scan position from the VGA timing driver and broadcasts it to NUM_LAYERS sprite sources (layer 0 = player plane, higher layers = enemies/bullets).
- Receives each source's colour and alpha, selects the highest-priority opaque layer per pixel and gathers per-frame collision flags.
- Runs an update-window handshake so game logic on clk_run changes sprite state only during vertical blanking.

Parameters:
- NUM_LAYERS, 4, number of sprite sources; index 0 has highest priority.
- RGB_W, 12, colour width (4:4:4).
- X_W, 10, horizontal address width.
- Y_W, 10, vertical address width.
- V_ACTIVE, 480, active lines per frame.
- BG_RGB, 12'h000, colour shown where no layer is opaque.

Ports:
- clk_vga  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- scan_x_i  in  X_W  pixel x address from the timing driver.
- scan_y_i  in  Y_W  pixel y address from the timing driver.
- scan_disp_i  in  1  active-video flag from the timing driver.
- lyr_x_o  out  X_W  broadcast x address to all layers.
- lyr_y_o  out  Y_W  broadcast y address to all layers.
- lyr_rgb_i  in  NUM_LAYERS*RGB_W  layer colours, layer k at bits [k*RGB_W +: RGB_W].
- lyr_alpha_i  in  NUM_LAYERS  per-layer opaque flag.
- pix_rgb_o  out  RGB_W  composited pixel.
- pix_valid_o  out  1  pix_rgb_o is active video.
- coll_o  out  NUM_LAYERS  per-frame collision flags; bit 0 always 0.
- frame_done_o  out  1  one-cycle pulse at frame end.
- upd_req_o  out  1  update window open.
- upd_ack_i  in  1  game logic finished its update.
- overrun_o  out  1  sticky: update window missed.

Behaviour:
- Reset values:
  - All outputs 0; pix_rgb_o = 0.
  - State = SCAN; all pipeline registers and sticky flags cleared.
  - Reset mid-frame discards all in-flight pixels and any open window.
- Address stage (cycle t):
  - lyr_x_o and lyr_y_o are combinational pass-through of scan_x_i and scan_y_i.
  - scan_disp_i is delayed by one register to d1.
- Layer latency is exactly 1 cycle: lyr_rgb_i and lyr_alpha_i at t+1 correspond to the address at t.
- Compose stage (registered at the t+1 edge, visible at t+2):
  - If d1 = 0: pix_rgb_o = 0, pix_valid_o = 0.
  - Otherwise pix_valid_o = 1 and pix_rgb_o = rgb of the lowest-index k with alpha[k] = 1, or BG_RGB if no layer is opaque.
  - Total latency from scan address to pix_rgb_o is 2 cycles.
- Collision accumulation:
  - While d1 = 1 and alpha[0] = 1, a frame-local sticky bit acc[k] (k ≥ 1) is set whenever alpha[k] = 1.
  - alpha is ignored when d1 = 0.
- FSM states are SCAN, DRAIN, REPORT and WINDOW.
  - SCAN: frame end is the falling edge of scan_disp_i while scan_y_i == V_ACTIVE-1. On frame end, go to DRAIN.
  - DRAIN: 2 cycles, so the last pixels are composed and accumulated. Then go to REPORT.
  - REPORT: 1 cycle. coll_o <= acc, acc <= 0, frame_done_o = 1 for this cycle only. Then go to WINDOW with upd_req_o = 1.
  - WINDOW: upd_req_o stays high until upd_ack_i is sampled high; then upd_req_o = 0 and the FSM returns to SCAN.
  - upd_ack_i high in the same cycle that upd_req_o rises is accepted.
  - upd_ack_i outside WINDOW is ignored.
- Overrun:
  - If scan_disp_i rises while in WINDOW, drop upd_req_o, set overrun_o and go to SCAN.
  - The collision accumulation for the new frame starts normally.
  - overrun_o clears only on rst.
- coll_o holds its value for a whole frame and changes only in REPORT.
- Compositing continues in every state; only the blanking output is forced to 0.

Test Plan:
- Reset: assert rst mid-line with alpha = 4'b1111 -> next cycle all outputs 0 and state SCAN; after release the first valid pixel appears 2 cycles after scan_disp_i = 1.
- Priority:
  - alpha = 4'b0110, rgb1 = 12'hF00, rgb2 = 12'h0F0 -> pix_rgb_o = 12'hF00 two cycles later.
  - alpha = 0 -> BG_RGB.
  - scan_disp_i = 0 -> 12'h000 with pix_valid_o = 0.
- Collision: alpha = 4'b1001 for one active pixel at (100,200), otherwise 4'b0001 -> after frame end, frame_done_o pulses once and coll_o = 4'b1000; next frame with no overlap gives coll_o = 4'b0000.
- Edge alignment: overlap only on the last active pixel (639,479) -> still captured (DRAIN); overlap during blanking -> not captured.
- Handshake: upd_ack_i raised 50 cycles after upd_req_o -> upd_req_o falls the next cycle, overrun_o stays 0; ack asserted in the same cycle upd_req_o rises -> accepted.
- Overrun: never ack -> upd_req_o drops at the next scan_disp_i rise, overrun_o = 1 and stays 1 across further frames until rst.
